axis_cmd_sequencer: RTL and testbench
=====================================

Name: axis_cmd_sequencer

Overview:
Host-side command sequencer that drives the slave AXI-stream port of axis_control_wrapper.
- Accepts one BRAM transfer command per handshake.
- Serialises the 6-word header, forwards the write payload from a source stream with a correct tlast, then waits for write_done/read_done.
- Reports completion or a coded error.
- Sits between the DMA/host command logic and the wrapper, so upstream never hand-builds headers.

Parameters:
DATA_WIDTH, 16, stream word width (header words zero-extended to this width)
BRAM_COUNT, 16, number of BRAMs; legal bram_end range 1..BRAM_COUNT
ADDR_WIDTH, 9, BRAM address width
MAGIC, 16'hC0DE, header magic word
TIMEOUT_CYCLES, 4096, maximum cycles in WAIT_DONE before timeout error

Ports:
aclk  in  1  clock, rising edge
aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  1  0 = write (instr 0x0001), 1 = read (instr 0x0002)
cmd_bram_start  in  5  first BRAM index
cmd_bram_end  in  5  end BRAM index, exclusive
cmd_addr_start  in  ADDR_WIDTH  start address
cmd_count  in  16  words per BRAM
src_tdata  in  DATA_WIDTH  write payload source
src_tvalid  in  1  payload valid
src_tready  out  1  payload ready
m_axis_tdata  out  DATA_WIDTH  to wrapper s_axis_tdata
m_axis_tvalid  out  1  to wrapper
m_axis_tready  in  1  from wrapper
m_axis_tlast  out  1  to wrapper
write_done  in  1  from wrapper
read_done  in  1  from wrapper
error_invalid_magic  in  1  from wrapper
busy  out  1  high in every state except IDLE
cmd_done  out  1  one-cycle completion pulse
cmd_error  out  1  one-cycle error pulse
err_code  out  2  0 none, 1 bad command, 2 magic error, 3 timeout; holds until next accepted command
words_sent  out  21  payload words forwarded for the current command

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - cmd_ready = 1.
  - All other outputs 0, including err_code and words_sent.
  - Reset mid-transfer aborts immediately; no tlast is emitted.
- States: IDLE, HDR, PAY, WAIT_DONE, DONE, ERR.
- IDLE, on cmd_valid&&cmd_ready:
  - Latch all cmd fields.
  - Compute total = (end-start)*count in 21 bits.
  - Clear err_code and words_sent.
  - Latch the current write_done/read_done levels as edge references.
  - If end<=start, end>BRAM_COUNT, or count==0: go to ERR with code 1, emitting nothing.
  - Otherwise go to HDR with hdr_idx = 0.
- HDR:
  - m_axis_tvalid = 1.
  - tdata by hdr_idx: MAGIC, instr, start, end, addr_start, count.
  - hdr_idx advances only on the m_axis handshake; tdata and tvalid are stable while stalled.
  - tlast is high only on word 5 when op = read.
  - After word 5: write goes to PAY, read goes to WAIT_DONE.
  - First header word is valid the cycle after command acceptance.
- PAY: combinational passthrough.
  - m_axis_tvalid = src_tvalid; m_axis_tdata = src_tdata; src_tready = m_axis_tready.
  - words_sent increments on each handshake.
  - m_axis_tlast = (words_sent == total-1).
  - The handshake on the final word goes to WAIT_DONE.
  - src_tready = 0 in every other state.
- WAIT_DONE:
  - Timeout counter runs from 0.
  - A rising edge of the relevant done (write_done for write, read_done for read), detected against the registered previous value, goes to DONE.
  - Counter reaching TIMEOUT_CYCLES-1 goes to ERR with code 3.
  - If a done edge and the timeout coincide, done wins.
- DONE: cmd_done = 1 for exactly that cycle, then IDLE.
- ERR: cmd_error = 1 for exactly that cycle, err_code is set, then IDLE.
- error_invalid_magic high in HDR, PAY or WAIT_DONE goes to ERR with code 2 on the next edge; it overrides a coincident done edge.
  - The stream is dropped without tlast; the wrapper is expected to resynchronise on the next magic word.
- m_axis_tvalid is never deasserted without a handshake, except on abort to ERR.
- cmd_valid is ignored outside IDLE.
- No combinational path from m_axis_tready to m_axis_tvalid, except the PAY passthrough.

Test Plan:
- Write, start = 2, end = 6, addr = 0, count = 42, ready always high:
  - m_axis carries C0DE, 0001, 0002, 0006, 0000, 002A, then payload 1..168 with tlast only on 168.
  - words_sent = 168.
  - write_done rising edge gives cmd_done one cycle later, busy = 0, err_code = 0.
- Same write with m_axis_tready toggling 1/0 every cycle and src_tvalid gapped:
  - No word lost, duplicated or changed while stalled.
  - Totals are identical to the first test.
- Read, start = 0, end = 1, addr = 5, count = 8:
  - Header words C0DE, 0002, 0000, 0001, 0005, 0008, with tlast on 0008.
  - src_tready stays 0.
  - read_done edge gives cmd_done.
- Bad commands (end = 2/start = 2; end = 17; count = 0):
  - No m_axis_tvalid.
  - cmd_error pulse, err_code = 1, back to IDLE in 2 cycles.
- Write with write_done never asserted:
  - cmd_error after TIMEOUT_CYCLES in WAIT_DONE, err_code = 3.
- error_invalid_magic pulsed mid-PAY: cmd_error, err_code = 2.
- aresetn dropped mid-PAY, then a fresh command: all outputs 0 during reset, and the next command restarts with a MAGIC word.

Source files
------------

// File: rtl/axis_cmd_sequencer.sv
// Host-side command sequencer for the axis_control_wrapper slave stream.
// Takes one BRAM transfer command, serialises its 6-word header, forwards the
// write payload with a correct tlast, then waits for the wrapper's done
// strobe. Completion and coded errors are reported as one-cycle pulses.
module axis_cmd_sequencer #(
  parameter int          DATA_WIDTH     = 16,
  parameter int          BRAM_COUNT     = 16,
  parameter int          ADDR_WIDTH     = 9,
  parameter logic [15:0] MAGIC          = 16'hC0DE,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [4:0]            cmd_bram_start,
  input  logic [4:0]            cmd_bram_end,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_start,
  input  logic [15:0]           cmd_count,
  input  logic [DATA_WIDTH-1:0] src_tdata,
  input  logic                  src_tvalid,
  output logic                  src_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic                  write_done,
  input  logic                  read_done,
  input  logic                  error_invalid_magic,
  output logic                  busy,
  output logic                  cmd_done,
  output logic                  cmd_error,
  output logic [1:0]            err_code,
  output logic [20:0]           words_sent
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            hdr_idx_q, hdr_idx_d;
  logic                  op_q, op_d;
  logic [4:0]            start_q, start_d;
  logic [4:0]            end_q, end_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           count_q, count_d;
  logic [20:0]           total_q, total_d;
  logic [20:0]           ws_q, ws_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  wd_prev_q, wd_prev_d;
  logic                  rd_prev_q, rd_prev_d;

  logic                  bad_cmd_s;
  logic [20:0]           total_s;
  logic                  done_edge_s;
  logic                  last_word_s;
  logic [DATA_WIDTH-1:0] hdr_word_s;

  // Command screening: empty/reversed range, range past the last BRAM, zero count.
  assign bad_cmd_s = (cmd_bram_end <= cmd_bram_start) ||
                     ({27'd0, cmd_bram_end} > 32'(BRAM_COUNT)) ||
                     (cmd_count == 16'd0);
  assign total_s   = 21'(cmd_bram_end - cmd_bram_start) * 21'(cmd_count);

  // Rising edge of the done strobe that belongs to the current operation,
  // measured against the level captured at acceptance / the previous cycle.
  assign done_edge_s = op_q ? (read_done  && !rd_prev_q)
                            : (write_done && !wd_prev_q);
  assign last_word_s = (ws_q == (total_q - 21'd1));

  // Header word selection by index; header fields are zero-extended.
  always_comb begin
    hdr_word_s = '0;
    case (hdr_idx_q)
      3'd0:    hdr_word_s = DATA_WIDTH'(MAGIC);
      3'd1:    hdr_word_s = op_q ? DATA_WIDTH'(16'h0002) : DATA_WIDTH'(16'h0001);
      3'd2:    hdr_word_s = DATA_WIDTH'(start_q);
      3'd3:    hdr_word_s = DATA_WIDTH'(end_q);
      3'd4:    hdr_word_s = DATA_WIDTH'(addr_q);
      3'd5:    hdr_word_s = DATA_WIDTH'(count_q);
      default: hdr_word_s = '0;
    endcase
  end

  // Next-state logic: command capture, header walk, payload count, done/timeout.
  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    op_d       = op_q;
    start_d    = start_q;
    end_d      = end_q;
    addr_d     = addr_q;
    count_d    = count_q;
    total_d    = total_q;
    ws_d       = ws_q;
    err_code_d = err_code_q;
    tmo_d      = '0;
    wd_prev_d  = wd_prev_q;
    rd_prev_d  = rd_prev_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          start_d    = cmd_bram_start;
          end_d      = cmd_bram_end;
          addr_d     = cmd_addr_start;
          count_d    = cmd_count;
          total_d    = total_s;
          ws_d       = 21'd0;
          err_code_d = 2'd0;
          wd_prev_d  = write_done;
          rd_prev_d  = read_done;
          hdr_idx_d  = 3'd0;
          if (bad_cmd_s) begin
            state_d    = S_ERR;
            err_code_d = 2'd1;
          end else begin
            state_d    = S_HDR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        if (error_invalid_magic) begin
          state_d    = S_ERR;
          err_code_d = 2'd2;
        end else if (m_axis_tready) begin
          if (hdr_idx_q == 3'd5) begin
            state_d = op_q ? S_WAIT : S_PAY;
          end else begin
            hdr_idx_d = hdr_idx_q + 3'd1;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_PAY: begin
        if (error_invalid_magic) begin
          state_d    = S_ERR;
          err_code_d = 2'd2;
        end else if (src_tvalid && m_axis_tready) begin
          ws_d = ws_q + 21'd1;
          if (last_word_s) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_PAY;
          end
        end else begin
          state_d = S_PAY;
        end
      end
      S_WAIT: begin
        wd_prev_d = write_done;
        rd_prev_d = read_done;
        tmo_d     = tmo_q + TW'(1);
        if (error_invalid_magic) begin
          state_d    = S_ERR;
          err_code_d = 2'd2;
        end else if (done_edge_s) begin
          state_d = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          state_d    = S_ERR;
          err_code_d = 2'd3;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and command registers; reset aborts any transfer in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      hdr_idx_q  <= 3'd0;
      op_q       <= 1'b0;
      start_q    <= 5'd0;
      end_q      <= 5'd0;
      addr_q     <= '0;
      count_q    <= 16'd0;
      total_q    <= 21'd0;
      ws_q       <= 21'd0;
      err_code_q <= 2'd0;
      tmo_q      <= '0;
      wd_prev_q  <= 1'b0;
      rd_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      op_q       <= op_d;
      start_q    <= start_d;
      end_q      <= end_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      total_q    <= total_d;
      ws_q       <= ws_d;
      err_code_q <= err_code_d;
      tmo_q      <= tmo_d;
      wd_prev_q  <= wd_prev_d;
      rd_prev_q  <= rd_prev_d;
    end
  end

  // Stream outputs: header words come from registers only; PAY is a passthrough.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    src_tready    = 1'b0;
    case (state_q)
      S_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_word_s;
        m_axis_tlast  = (hdr_idx_q == 3'd5) && op_q;
      end
      S_PAY: begin
        m_axis_tvalid = src_tvalid;
        m_axis_tdata  = src_tdata;
        m_axis_tlast  = last_word_s;
        src_tready    = m_axis_tready;
      end
      default: begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        src_tready    = 1'b0;
      end
    endcase
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign cmd_done   = (state_q == S_DONE);
  assign cmd_error  = (state_q == S_ERR);
  assign err_code   = err_code_q;
  assign words_sent = ws_q;

endmodule

// File: tb/tb_axis_cmd_sequencer.sv
// Scoreboard bench for axis_cmd_sequencer: expected stream words are queued
// when a command is issued and popped as m_axis handshakes occur.
module tb_axis_cmd_sequencer;

  localparam int DW  = 16;
  localparam int AW  = 9;
  localparam int TMO = 4096;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic [4:0]    cmd_bram_start = 5'd0;
  logic [4:0]    cmd_bram_end = 5'd0;
  logic [AW-1:0] cmd_addr_start = '0;
  logic [15:0]   cmd_count = 16'd0;
  logic [DW-1:0] src_tdata = '0;
  logic          src_tvalid = 1'b0;
  logic          src_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          write_done = 1'b0;
  logic          read_done = 1'b0;
  logic          error_invalid_magic = 1'b0;
  logic          busy;
  logic          cmd_done;
  logic          cmd_error;
  logic [1:0]    err_code;
  logic [20:0]   words_sent;

  always #5 aclk = ~aclk;

  axis_cmd_sequencer #(
    .DATA_WIDTH(DW), .BRAM_COUNT(16), .ADDR_WIDTH(AW),
    .MAGIC(16'hC0DE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_bram_start(cmd_bram_start), .cmd_bram_end(cmd_bram_end),
    .cmd_addr_start(cmd_addr_start), .cmd_count(cmd_count),
    .src_tdata(src_tdata), .src_tvalid(src_tvalid), .src_tready(src_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .write_done(write_done), .read_done(read_done),
    .error_invalid_magic(error_invalid_magic),
    .busy(busy), .cmd_done(cmd_done), .cmd_error(cmd_error),
    .err_code(err_code), .words_sent(words_sent)
  );

  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW:0]   exp_q[$];

  int            cyc, src_idx, n_payload;
  int            first_valid_idx, done_idx, err_idx, done_rise_idx, last_hs_idx;
  int            n_tvalid_hi, n_src_hi;
  bit            done_seen, err_seen, stall_pend, stall_last, src_hs, magic_sent, stopped, cur_op;
  logic [DW-1:0] stall_data;
  logic [1:0]    code_at_end;
  logic [20:0]   ws_at_end;

  // Issue a command (at the drive phase) and queue the words it should produce.
  task automatic send_cmd(input bit op, input int bs, input int be, input int addr, input int cnt);
    bit good;
    int n;
    good = (be > bs) && (be <= 16) && (cnt != 0);
    n = (good && !op) ? (be - bs) * cnt : 0;
    cmd_op = op;
    cmd_bram_start = 5'(bs);
    cmd_bram_end = 5'(be);
    cmd_addr_start = AW'(addr);
    cmd_count = 16'(cnt);
    cmd_valid = 1'b1;
    cyc = 0; src_idx = 0; n_payload = n; cur_op = op;
    first_valid_idx = -1; done_idx = -1; err_idx = -1; done_rise_idx = -1; last_hs_idx = -1;
    n_tvalid_hi = 0; n_src_hi = 0;
    done_seen = 1'b0; err_seen = 1'b0; stall_pend = 1'b0; src_hs = 1'b0;
    magic_sent = 1'b0; stopped = 1'b0;
    if (good) begin
      exp_q.push_back({1'b0, DW'(16'hC0DE)});
      exp_q.push_back({1'b0, op ? DW'(16'h0002) : DW'(16'h0001)});
      exp_q.push_back({1'b0, DW'(bs)});
      exp_q.push_back({1'b0, DW'(be)});
      exp_q.push_back({1'b0, DW'(addr)});
      exp_q.push_back({op, DW'(cnt)});
      for (int i = 1; i <= n; i++) exp_q.push_back({(i == n), DW'(i)});
    end
  endtask

  // Clock-by-clock engine: monitor on negedge, drive #1 after posedge.
  task automatic run(input int budget, input bit toggle, input bit gap,
                     input bit do_done, input int magic_at, input int stop_at);
    logic [DW:0] e;
    while (!done_seen && !err_seen && !stopped && cyc < budget) begin
      @(negedge aclk);
      cyc++;
      if (m_axis_tvalid) begin
        n_tvalid_hi++;
        if (first_valid_idx < 0) first_valid_idx = cyc;
      end
      if (src_tready) n_src_hi++;
      if (stall_pend) begin
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== stall_data || m_axis_tlast !== stall_last) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%0b data=%0h last=%0b, expected valid=1 data=%0h last=%0b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, stall_data, stall_last);
        end
      end
      stall_pend = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
      stall_last = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        n_checks++;
        last_hs_idx = cyc;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_word: got data=%0h last=%0b, expected no word", m_axis_tdata, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            n_fail++;
            $display("FAIL stream_word: got data=%0h last=%0b, expected data=%0h last=%0b",
                     m_axis_tdata, m_axis_tlast, e[DW-1:0], e[DW]);
          end
        end
      end
      src_hs = src_tvalid && src_tready;
      if (src_hs) src_idx++;
      if (cmd_done) begin done_seen = 1'b1; done_idx = cyc; code_at_end = err_code; ws_at_end = words_sent; end
      if (cmd_error) begin err_seen = 1'b1; err_idx = cyc; code_at_end = err_code; ws_at_end = words_sent; end
      @(posedge aclk);
      #1;
      cmd_valid = 1'b0;
      error_invalid_magic = 1'b0;
      if (magic_at >= 0 && src_idx == magic_at && !magic_sent) begin
        error_invalid_magic = 1'b1;
        magic_sent = 1'b1;
      end
      m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
      if (!src_tvalid || src_hs) begin
        if (src_idx < n_payload && (!gap || $urandom_range(0, 3) != 0)) begin
          src_tvalid = 1'b1;
          src_tdata = DW'(src_idx + 1);
        end else begin
          src_tvalid = 1'b0;
        end
      end
      if (do_done && done_rise_idx < 0 && exp_q.size() == 0 && last_hs_idx > 0 && cyc >= last_hs_idx + 3) begin
        if (cur_op) read_done = 1'b1;
        else write_done = 1'b1;
        done_rise_idx = cyc + 1;
      end
      stopped = (stop_at >= 0) && (src_idx >= stop_at);
    end
    n_checks++;
    if (!done_seen && !err_seen && !stopped) begin
      n_fail++;
      $display("FAIL run_budget: got no completion in %0d cycles, expected cmd_done or cmd_error", budget);
    end
  endtask

  // Return inputs to idle levels at the drive phase.
  task automatic quiesce();
    @(posedge aclk);
    #1;
    write_done = 1'b0; read_done = 1'b0; src_tvalid = 1'b0;
    m_axis_tready = 1'b1; error_invalid_magic = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge aclk);
    n_checks++;
    if ({cmd_ready, busy, cmd_done, cmd_error, m_axis_tvalid, m_axis_tlast, src_tready} !== 7'b1000000 ||
        err_code !== 2'd0 || words_sent !== 21'd0 || m_axis_tdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%0b busy=%0b done=%0b err=%0b tv=%0b code=%0d ws=%0d, expected ready=1 and all others 0",
               cmd_ready, busy, cmd_done, cmd_error, m_axis_tvalid, err_code, words_sent);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%0b busy=%0b, expected ready=1 busy=0", cmd_ready, busy);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_write_basic();
    send_cmd(1'b0, 2, 6, 0, 42);
    run(400, 1'b0, 1'b0, 1'b1, -1, -1);
    n_checks++;
    if (!done_seen || code_at_end !== 2'd0 || ws_at_end !== 21'd168) begin
      n_fail++;
      $display("FAIL write_done: got done=%0b code=%0d ws=%0d, expected done=1 code=0 ws=168", done_seen, code_at_end, ws_at_end);
    end
    n_checks++;
    if (first_valid_idx != 2 || done_idx - done_rise_idx != 1) begin
      n_fail++;
      $display("FAIL write_latency: got first=%0d done_lag=%0d, expected first=2 done_lag=1", first_valid_idx, done_idx - done_rise_idx);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL write_words: got %0d words missing, expected 0", exp_q.size());
    end
    @(negedge aclk);
    n_checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL write_idle: got busy=%0b ready=%0b code=%0d, expected busy=0 ready=1 code=0", busy, cmd_ready, err_code);
    end
    quiesce();
  endtask

  task automatic test_write_stall();
    send_cmd(1'b0, 2, 6, 0, 42);
    run(3000, 1'b1, 1'b1, 1'b1, -1, -1);
    n_checks++;
    if (!done_seen || code_at_end !== 2'd0 || ws_at_end !== 21'd168 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_totals: got done=%0b code=%0d ws=%0d left=%0d, expected done=1 code=0 ws=168 left=0",
               done_seen, code_at_end, ws_at_end, exp_q.size());
    end
    quiesce();
    exp_q.delete();
  endtask

  task automatic test_read();
    send_cmd(1'b1, 0, 1, 5, 8);
    run(200, 1'b0, 1'b0, 1'b1, -1, -1);
    n_checks++;
    if (!done_seen || exp_q.size() != 0 || done_idx - done_rise_idx != 1) begin
      n_fail++;
      $display("FAIL read_done: got done=%0b left=%0d lag=%0d, expected done=1 left=0 lag=1", done_seen, exp_q.size(), done_idx - done_rise_idx);
    end
    n_checks++;
    if (n_src_hi != 0 || ws_at_end !== 21'd0) begin
      n_fail++;
      $display("FAIL read_src_idle: got src_ready_cycles=%0d ws=%0d, expected 0 and 0", n_src_hi, ws_at_end);
    end
    quiesce();
  endtask

  task automatic test_bad_cmds();
    int bs_t[3] = '{2, 0, 0};
    int be_t[3] = '{2, 17, 4};
    int cn_t[3] = '{42, 4, 0};
    for (int k = 0; k < 3; k++) begin
      send_cmd(1'b0, bs_t[k], be_t[k], 0, cn_t[k]);
      run(10, 1'b0, 1'b0, 1'b0, -1, -1);
      n_checks++;
      if (!err_seen || err_idx != 2 || code_at_end !== 2'd1 || n_tvalid_hi != 0) begin
        n_fail++;
        $display("FAIL bad_cmd%0d: got err=%0b at=%0d code=%0d tvalid_cycles=%0d, expected err=1 at=2 code=1 tvalid_cycles=0",
                 k, err_seen, err_idx, code_at_end, n_tvalid_hi);
      end
      @(negedge aclk);
      n_checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || err_code !== 2'd1) begin
        n_fail++;
        $display("FAIL bad_cmd%0d_idle: got ready=%0b busy=%0b code=%0d, expected 1 0 1", k, cmd_ready, busy, err_code);
      end
      quiesce();
    end
  endtask

  task automatic test_timeout();
    send_cmd(1'b0, 0, 1, 0, 4);
    run(TMO + 200, 1'b0, 1'b0, 1'b0, -1, -1);
    n_checks++;
    if (!err_seen || code_at_end !== 2'd3 || ws_at_end !== 21'd4) begin
      n_fail++;
      $display("FAIL timeout_code: got err=%0b code=%0d ws=%0d, expected err=1 code=3 ws=4", err_seen, code_at_end, ws_at_end);
    end
    n_checks++;
    if (err_idx - last_hs_idx != TMO + 1) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d cycles, expected %0d", err_idx - last_hs_idx, TMO + 1);
    end
    quiesce();
  endtask

  task automatic test_magic_abort();
    send_cmd(1'b0, 2, 6, 0, 42);
    run(400, 1'b0, 1'b0, 1'b1, 30, -1);
    n_checks++;
    if (!err_seen || done_seen || code_at_end !== 2'd2) begin
      n_fail++;
      $display("FAIL magic_abort: got err=%0b done=%0b code=%0d, expected err=1 done=0 code=2", err_seen, done_seen, code_at_end);
    end
    @(negedge aclk);
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || err_code !== 2'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL magic_idle: got tvalid=%0b code=%0d busy=%0b, expected 0 2 0", m_axis_tvalid, err_code, busy);
    end
    quiesce();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_pay();
    send_cmd(1'b0, 2, 6, 0, 42);
    run(400, 1'b0, 1'b0, 1'b1, -1, 20);
    #2;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, busy, cmd_done, cmd_error, m_axis_tvalid, m_axis_tlast, src_tready} !== 7'b1000000 ||
        err_code !== 2'd0 || words_sent !== 21'd0 || m_axis_tdata !== '0) begin
      n_fail++;
      $display("FAIL midpay_reset: got ready=%0b busy=%0b tv=%0b last=%0b srdy=%0b code=%0d ws=%0d, expected ready=1 rest 0",
               cmd_ready, busy, m_axis_tvalid, m_axis_tlast, src_tready, err_code, words_sent);
    end
    quiesce();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    exp_q.delete();
    send_cmd(1'b0, 0, 1, 3, 2);
    run(100, 1'b0, 1'b0, 1'b1, -1, -1);
    n_checks++;
    if (!done_seen || first_valid_idx != 2 || exp_q.size() != 0 || ws_at_end !== 21'd2) begin
      n_fail++;
      $display("FAIL restart_cmd: got done=%0b first=%0d left=%0d ws=%0d, expected done=1 first=2 left=0 ws=2",
               done_seen, first_valid_idx, exp_q.size(), ws_at_end);
    end
    quiesce();
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_stall();
    test_read();
    test_bad_cmds();
    test_timeout();
    test_magic_abort();
    test_reset_mid_pay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
